fifo_traffic_gen: RTL and testbench
===================================

# fifo_traffic_gen

Parametrised FIFO exerciser for board bring-up and simulation. It contains its own synchronous FIFO and writes an incrementing data pattern in bursts. It reads the data back and checks it word by word, in either alternating-phase or concurrent mode. It also counts completed rounds and data errors, so FIFO behaviour can be checked on hardware through ILA/LEDs without a testbench.

## Interface
- DATA_W, 6, data word width (≥2)
- DEPTH, 32, FIFO depth in words; power of two, ≥4
- BURST, 32, words written and read per round; 1 ≤ BURST ≤ DEPTH (elaboration error otherwise)
- LVL_W, $clog2(DEPTH)+1, width of level output (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; high starts/continues rounds, low stops at next round boundary
- mode  in  1  0 = alternate (write burst then read burst), 1 = concurrent; sampled only when leaving IDLE
- inj_err  in  1  pulse; inverts bit 0 of the next accepted write word
- din  out  DATA_W  word presented to FIFO
- wr_en  out  1  FIFO write strobe
- rd_en  out  1  FIFO read strobe
- dout  out  DATA_W  FIFO read data
- full, empty  out  1  FIFO flags
- level  out  LVL_W  words currently stored (0..DEPTH)
- busy  out  1  state ≠ IDLE
- round_cnt  out  16  completed rounds, wraps at 2^16
- err_cnt  out  16  mismatches, saturates at 16'hFFFF
- err  out  1  sticky, set on first mismatch, cleared only by rst

## Operation
- States:
  - IDLE: if run=1, latch mode and go to WR (mode 0) or CONC (mode 1).
  - WR: go to RD when BURST writes are accepted.
  - RD: when BURST reads are accepted and the last compare is done, go to WR if run=1, else IDLE.
  - CONC: when BURST writes and BURST reads are accepted and the last compare is done, go to CONC if run=1, else IDLE.
- wr_en = (state ∈ {WR, CONC}) & !full & (wr_done < BURST). This is combinational, so overflow cannot occur.
- rd_en = (state ∈ {RD, CONC}) & !empty & (rd_done < BURST). Underflow cannot occur.
- din = wr_seq, or wr_seq ^ 1 when an injection is pending. wr_seq is a registered DATA_W counter, incremented per accepted write, wrapping 2^DATA_W−1 → 0.
  - inj_err sets a pending flag, cleared by the next accepted write.
- Checker: one cycle after an accepted read, compare dout against exp_seq.
  - exp_seq is a DATA_W counter, incremented per accepted read, with the same wrap as wr_seq.
  - On mismatch: err_cnt++ (saturating) and err=1.
- wr_done and rd_done clear at each round start. wr_seq and exp_seq are never cleared except by rst, so the pattern continues across rounds.
- round_cnt increments on each RD→(WR|IDLE) or CONC→(CONC|IDLE) transition.
- FIFO behaviour:
  - Simultaneous read and write: both are performed, level unchanged.
  - full = (level == DEPTH); empty = (level == 0).
- Reset, including mid-burst: FIFO contents are discarded.
  - Cleared to 0: all counters, pointers, level, din, dout, wr_en, rd_en, full, busy, err, err_cnt, round_cnt.
  - empty = 1; state = IDLE.
- run dropped mid-round: the round completes; run is not aborted.

## Timing
- run high in cycle N, with state IDLE → busy=1 and first wr_en=1 with din=0 in cycle N+1.
- Flags and level are registered and update the cycle after the accepted access.
  - Mode 0 with BURST=DEPTH: full=1 after the 32nd write.
  - WR→RD in the same cycle; first rd_en the cycle after.
- Read latency: 1 cycle. dout is valid in the cycle after rd_en is accepted, and holds until the next accepted read.
- Round turnaround in mode 0 (last compare → next first write): 1 cycle.

## Structure
- Shared package fifo_tg_pkg:
  - state enum (IDLE, WR, RD, CONC)
  - MODE_ALT/MODE_CONC constants
  - counter width constant (16)
- One sub-module, sync_fifo:
  - parameters DATA_W, DEPTH
  - ports clk, rst, wr_en, din, rd_en, dout, full, empty, level
  - implementation: registered read, pointers of $clog2(DEPTH)+1 bits
- The top level holds the FSM, pattern counters, injection flag and checker.

## Test plan
- Reset: apply rst for 3 cycles. All outputs are 0 except empty=1; state is IDLE.
- Mode 0, one round: run=1 for 1 cycle, defaults.
  - din 0..31 on 32 consecutive wr_en cycles; full=1, level=32.
  - 32 reads return dout 0..31.
  - round_cnt=1, err_cnt=0, busy then 0.
- Mode 0, run held for 3 rounds: round 2 writes/reads 32..63; round 3 wraps to 0..31. err_cnt=0, round_cnt=3.
- Mode 1, run held:
  - level never exceeds 1 and full never asserts.
  - After 2 rounds, round_cnt=2, exp_seq=0 (wrapped at 64), err_cnt=0.
- Injection: pulse inj_err before the 5th write of round 1 (word 4).
  - Written value is 5.
  - Cycle after read 5: err=1, err_cnt=1. All other words match.
- Reset mid-op: assert rst after the 10th write, release, then raise run.
  - level=0, empty=1.
  - Writes restart at din=0; full round passes with err_cnt=0.

Source files
------------

// File: rtl/fifo_tg_pkg.sv
// fifo_tg_pkg: shared FSM states, mode encodings and counter width for the FIFO traffic generator
package fifo_tg_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, CONC} state_t;
    localparam logic MODE_ALT  = 1'b0;
    localparam logic MODE_CONC = 1'b1;
    localparam int   CNT_W     = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered flags/level
// Ports: clk, rst (async, active-high); wr_en/din push a word, rd_en pops one into dout
// on the next edge; full/empty/level reflect contents after the previous edge.
module sync_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, level_nx;
    logic do_wr, do_rd;
    // Guard against misuse so the pointers can never run past each other.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign level_nx = level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                dout   <= mem[rd_ptr[AW-1:0]];
            end
            level <= level_nx;
            full  <= level_nx == FULL_LVL;
            empty <= level_nx == '0;
        end
endmodule

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: writes an incrementing pattern into its own FIFO in bursts and checks it on readback
// Ports: clk, rst (async, active-high); run starts/continues rounds; mode 0 = write burst then read
// burst, 1 = concurrent; inj_err flips bit 0 of the next accepted write. FIFO strobes/data/flags/level
// are exported for observation; busy, round_cnt, err_cnt (saturating) and sticky err report progress.
module fifo_traffic_gen
    import fifo_tg_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 32,
    parameter int BURST  = 32,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mode,
    input  logic              inj_err,
    output logic [DATA_W-1:0] din,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              busy,
    output logic [CNT_W-1:0]  round_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err
);
    if (DATA_W < 2) begin : g_bad_width
        $error("DATA_W must be at least 2");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two of at least 4");
    end
    if (BURST < 1 || BURST > DEPTH) begin : g_bad_burst
        $error("BURST must lie in 1..DEPTH");
    end
    localparam logic [LVL_W-1:0] BURST_C  = LVL_W'(BURST);
    localparam logic [LVL_W-1:0] BURST_M1 = LVL_W'(BURST - 1);
    state_t state, state_nx;
    logic [LVL_W-1:0] wr_done, rd_done;
    logic [DATA_W-1:0] wr_seq, exp_seq;
    logic inj_pend, chk, wr_fin, rd_fin, round_start, round_end;
    assign wr_en  = (state == WR || state == CONC) && !full && wr_done < BURST_C;
    assign rd_en  = (state == RD || state == CONC) && !empty && rd_done < BURST_C;
    assign din    = wr_seq ^ DATA_W'(inj_pend);
    assign busy   = state != IDLE;
    assign wr_fin = wr_done == BURST_C;
    assign rd_fin = rd_done == BURST_C;
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (rd_en),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );
    // rd_done reaches BURST in the same cycle the final word is compared, so
    // leaving RD/CONC on rd_fin coincides with the last compare.
    always_comb begin
        state_nx    = state;
        round_start = 1'b0;
        round_end   = 1'b0;
        case (state)
            IDLE: if (run) begin
                state_nx    = (mode == MODE_CONC) ? CONC : WR;
                round_start = 1'b1;
            end
            WR: if (wr_en && wr_done == BURST_M1) state_nx = RD;
            RD: if (rd_fin) begin
                state_nx    = run ? WR : IDLE;
                round_end   = 1'b1;
                round_start = run;
            end
            CONC: if (wr_fin && rd_fin) begin
                state_nx    = run ? CONC : IDLE;
                round_end   = 1'b1;
                round_start = run;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            wr_done   <= '0;
            rd_done   <= '0;
            wr_seq    <= '0;
            exp_seq   <= '0;
            inj_pend  <= 1'b0;
            chk       <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            round_cnt <= '0;
        end else begin
            state    <= state_nx;
            wr_done  <= round_start ? '0 : wr_done + LVL_W'(wr_en);
            rd_done  <= round_start ? '0 : rd_done + LVL_W'(rd_en);
            inj_pend <= inj_err | (inj_pend & ~wr_en);
            chk      <= rd_en;
            if (wr_en) wr_seq <= wr_seq + DATA_W'(1);
            // exp_seq advances as each read is checked, keeping it aligned with dout.
            if (chk) exp_seq <= exp_seq + DATA_W'(1);
            if (chk && dout != exp_seq) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
            if (round_end) round_cnt <= round_cnt + CNT_W'(1);
        end
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: directed self-checking bench for fifo_traffic_gen with default parameters
module tb_fifo_traffic_gen;
    localparam int DW    = 6;
    localparam int BURST = 32;
    localparam int LW    = 6;
    localparam int LIMIT = 5000;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, mode = 1'b0, inj_err = 1'b0;
    logic [DW-1:0] din, dout;
    logic wr_en, rd_en, full, empty, busy, err;
    logic [LW-1:0] level;
    logic [15:0] round_cnt, err_cnt;
    int n_cmp = 0, n_bad = 0;
    int wseq = 0, rseq = 0, rounds = 0;
    always #5 clk = ~clk;
    fifo_traffic_gen dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mode      (mode),
        .inj_err   (inj_err),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .busy      (busy),
        .round_cnt (round_cnt),
        .err_cnt   (err_cnt),
        .err       (err)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_din"}, 32'(din), 0);
        check({tag, "_dout"}, 32'(dout), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
        check({tag, "_round_cnt"}, 32'(round_cnt), 0);
    endtask
    task automatic apply_reset;
        rst = 1'b1;
        run = 1'b0;
        inj_err = 1'b0;
        repeat (3) tick();
        check_idle_outputs("rst");
        rst = 1'b0;
        wseq = 0;
        rseq = 0;
        rounds = 0;
    endtask
    // Runs n rounds; inj is the in-call word index to corrupt (-1 for none).
    task automatic run_rounds(input int n, input logic md, input int inj);
        int wi = 0, ri = 0, cyc = 0, max_lvl = 0;
        bit prev_rd = 0, saw_full = 0, err_next = 0;
        int target = rounds + n;
        mode = md;
        run = 1'b1;
        tick();
        check("start_busy", 32'(busy), 1);
        check("start_wr_en", 32'(wr_en), 1);
        check("start_din", 32'(din), 32'(wseq & 63));
        while (!(round_cnt == 16'(target) && !busy) && cyc < LIMIT) begin
            if (err_next) begin
                check("err_after_inj", 32'(err), 1);
                check("err_cnt_after_inj", 32'(err_cnt), 1);
                err_next = 0;
            end
            if (prev_rd) begin
                check("dout", 32'(dout), 32'((rseq ^ int'(ri == inj)) & 63));
                if (ri == inj) err_next = 1;
                rseq++;
                ri++;
            end
            prev_rd = rd_en;
            inj_err = wr_en && wi == inj - 1;
            if (wr_en) begin
                check("din", 32'(din), 32'((wseq ^ int'(wi == inj)) & 63));
                wseq++;
                wi++;
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
            saw_full |= full;
            if (int'(round_cnt) >= target - 1) run = 1'b0;
            tick();
            cyc++;
        end
        inj_err = 1'b0;
        run = 1'b0;
        check("round_timeout", 32'(cyc < LIMIT), 1);
        rounds = target;
        check("round_cnt", 32'(round_cnt), 32'(target));
        check("busy_end", 32'(busy), 0);
        check("words_written", 32'(wi), 32'(n * BURST));
        check("words_read", 32'(ri), 32'(n * BURST));
        if (md) begin
            check("conc_max_level", 32'(max_lvl), 1);
            check("conc_full_seen", 32'(saw_full), 0);
        end else begin
            check("alt_max_level", 32'(max_lvl), 32'(BURST));
            check("alt_full_seen", 32'(saw_full), 1);
        end
    endtask
    initial begin
        int wi, cyc;
        apply_reset();
        run_rounds(1, 1'b0, -1);
        check("one_round_err_cnt", 32'(err_cnt), 0);
        run_rounds(3, 1'b0, -1);
        check("three_round_err_cnt", 32'(err_cnt), 0);
        run_rounds(2, 1'b1, -1);
        check("conc_err_cnt", 32'(err_cnt), 0);
        check("conc_err", 32'(err), 0);
        apply_reset();
        run_rounds(1, 1'b0, 4);
        check("inj_err_sticky", 32'(err), 1);
        check("inj_err_cnt", 32'(err_cnt), 1);
        mode = 1'b0;
        run = 1'b1;
        wi = 0;
        cyc = 0;
        tick();
        while (wi < 10 && cyc < 100) begin
            if (wr_en) wi++;
            if (wi < 10) begin
                tick();
                cyc++;
            end
        end
        run = 1'b0;
        tick();
        check("mid_writes", 32'(wi), 10);
        check("mid_level", 32'(level), 10);
        rst = 1'b1;
        #1;
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(err), 0);
        tick();
        apply_reset();
        run_rounds(1, 1'b0, -1);
        check("post_rst_err_cnt", 32'(err_cnt), 0);
        check("post_rst_err", 32'(err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
